// File: rtl/rgb_led_pwm_fader.sv
// ============================================================================
// rgb_led_pwm_fader
//
// Downstream stage of the traffic-light LED sequencer. Takes the sequencer's
// three on/off requests and drives the physical RGB pins with PWM brightness.
// With RGB_FADE_EN defined, each channel moves one LSB per step tick toward
// its target instead of switching hard. When more than one request is active
// at the same time, all channels are driven dark until the overlap clears.
//
// Build option:
//   RGB_FADE_EN  defined   : linear fading, one LSB per STEP_CYCLES clocks.
//                undefined : levels follow their targets every clock, the
//                            step timer is not built and busy reads 0.
//
// Parameters:
//   PWM_BITS     width of brightness/level values; PWM period is
//                2^PWM_BITS-1 clocks.
//   STEP_CYCLES  clocks per one-LSB fade step.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   red_in      in   red request from the sequencer
//   green_in    in   green request from the sequencer
//   blue_in     in   blue request from the sequencer
//   brightness  in   on-level for whichever channel is requested
//   red_pwm     out  PWM drive to the red LED (registered)
//   green_pwm   out  PWM drive to the green LED (registered)
//   blue_pwm    out  PWM drive to the blue LED (registered)
//   busy        out  high while any channel is ramping
//   conflict    out  high while more than one request is active (registered)
// ============================================================================
module rgb_led_pwm_fader #(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 390_625
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                red_in,
    input  logic                green_in,
    input  logic                blue_in,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                red_pwm,
    output logic                green_pwm,
    output logic                blue_pwm,
    output logic                busy,
    output logic                conflict
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    localparam int NCH = 3;

    // Full-scale level; the PWM counter stops one short of it so that a
    // full-scale level is strictly greater than every counter value.
    localparam logic [PWM_BITS-1:0] LVL_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_TOP = LVL_MAX - PWM_BITS'(1);

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    function automatic state_t eval_state(input logic [PWM_BITS-1:0] lvl,
                                          input logic [PWM_BITS-1:0] tgt);
        state_t s;
        if (lvl < tgt) begin
            s = ST_UP;
        end else if (lvl > tgt) begin
            s = ST_DOWN;
        end else if (tgt == '0) begin
            s = ST_OFF;
        end else begin
            s = ST_ON;
        end
        return s;
    endfunction

    function automatic logic is_moving(input state_t s);
        return (s == ST_UP) || (s == ST_DOWN);
    endfunction

`ifdef RGB_FADE_EN
    function automatic logic [PWM_BITS-1:0] sat_inc(input logic [PWM_BITS-1:0] v);
        return (v == LVL_MAX) ? v : v + PWM_BITS'(1);
    endfunction

    function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] v);
        return (v == '0) ? v : v - PWM_BITS'(1);
    endfunction

    // One LSB toward the target; equal levels hold, so no overshoot.
    function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] lvl,
                                                        input logic [PWM_BITS-1:0] tgt);
        logic [PWM_BITS-1:0] r;
        if (lvl < tgt) begin
            r = sat_inc(lvl);
        end else if (lvl > tgt) begin
            r = sat_dec(lvl);
        end else begin
            r = lvl;
        end
        return r;
    endfunction
`endif

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [NCH-1:0]      req_q;
    logic [NCH-1:0]      req_d;
    logic                ovl;
    logic                conflict_q;

    logic [PWM_BITS-1:0] target [NCH];
    logic [PWM_BITS-1:0] lvl_q  [NCH];
    logic [PWM_BITS-1:0] lvl_d  [NCH];
    state_t              state_q [NCH];
    state_t              state_d [NCH];

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic [NCH-1:0]      pwm_q;
    logic [NCH-1:0]      pwm_d;

`ifdef RGB_FADE_EN
    // ------------------------------------------------------------------------
    // Step timer: free-running 0..STEP_CYCLES-1, tick on the last count
    // ------------------------------------------------------------------------
    localparam int TMR_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic             tick;

    assign tick  = (tmr_q == TMR_LAST);
    assign tmr_d = tick ? '0 : tmr_q + TMR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Overlap detection on the registered requests (two or more set)
    // ------------------------------------------------------------------------
    assign req_d = {blue_in, green_in, red_in};
    assign ovl   = (req_q[0] & req_q[1]) |
                   (req_q[0] & req_q[2]) |
                   (req_q[1] & req_q[2]);

    assign pwm_cnt_d = (pwm_cnt_q == PWM_TOP) ? '0 : pwm_cnt_q + PWM_BITS'(1);

    // ------------------------------------------------------------------------
    // Per-channel target, level and state next values
    // ------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            target[i] = (req_q[i] && !ovl) ? brightness : '0;
`ifdef RGB_FADE_EN
            // The step compares against the target of this very clock, so a
            // target change coinciding with a tick is already honoured.
            lvl_d[i] = tick ? step_toward(lvl_q[i], target[i]) : lvl_q[i];
`else
            lvl_d[i] = target[i];
`endif
            // State reflects the channel after this clock's update; without
            // fading lvl_d always equals the target, so UP/DOWN never occur.
            state_d[i] = eval_state(lvl_d[i], target[i]);
            pwm_d[i]   = (lvl_q[i] > pwm_cnt_q);
        end
    end

    // ------------------------------------------------------------------------
    // Registers: request capture, conflict, levels, channel FSMs, PWM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q      <= '0;
            conflict_q <= 1'b0;
            pwm_cnt_q  <= '0;
            pwm_q      <= '0;
            for (int i = 0; i < NCH; i++) begin
                lvl_q[i]   <= '0;
                state_q[i] <= ST_OFF;
            end
        end else begin
            req_q      <= req_d;
            conflict_q <= ovl;
            pwm_cnt_q  <= pwm_cnt_d;
            pwm_q      <= pwm_d;
            for (int i = 0; i < NCH; i++) begin
                lvl_q[i]   <= lvl_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs; busy decodes registered states only
    // ------------------------------------------------------------------------
    assign red_pwm   = pwm_q[0];
    assign green_pwm = pwm_q[1];
    assign blue_pwm  = pwm_q[2];
    assign conflict  = conflict_q;
    assign busy      = is_moving(state_q[0]) |
                       is_moving(state_q[1]) |
                       is_moving(state_q[2]);

endmodule

// File: tb/tb_rgb_led_pwm_fader.sv
// Testbench for rgb_led_pwm_fader (PWM_BITS=4, STEP_CYCLES=4).
// Works with RGB_FADE_EN either defined or undefined.
module tb_rgb_led_pwm_fader;

    localparam int PWM_BITS    = 4;
    localparam int STEP_CYCLES = 4;
    localparam int PERIOD      = 15;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                red_in = 1'b0;
    logic                green_in = 1'b0;
    logic                blue_in = 1'b0;
    logic [PWM_BITS-1:0] brightness = '0;
    logic                red_pwm;
    logic                green_pwm;
    logic                blue_pwm;
    logic                busy;
    logic                conflict;

    int checks = 0;
    int errors = 0;

    // Reference model: request/level/counter state at spec level
    int m_req [3];
    int m_lvl [3];
    bit mp    [3];
    int m_cnt;
    int m_tmr;
    bit m_conf;
    bit m_busy;

    always #5 clk = ~clk;

    rgb_led_pwm_fader #(
        .PWM_BITS   (PWM_BITS),
        .STEP_CYCLES(STEP_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .red_in    (red_in),
        .green_in  (green_in),
        .blue_in   (blue_in),
        .brightness(brightness),
        .red_pwm   (red_pwm),
        .green_pwm (green_pwm),
        .blue_pwm  (blue_pwm),
        .busy      (busy),
        .conflict  (conflict)
    );

    // Advance one clock: update the model from the inputs seen at the edge,
    // then return at the falling edge where outputs are compared.
    task automatic clk_step();
        int  in_req [3];
        int  n;
        int  tgt;
        bit  ovl;
        bit  tick;
        bit  any_move;
        @(posedge clk);
        in_req[0] = red_in   ? 1 : 0;
        in_req[1] = green_in ? 1 : 0;
        in_req[2] = blue_in  ? 1 : 0;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_req[i] = 0;
                m_lvl[i] = 0;
                mp[i]    = 1'b0;
            end
            m_cnt  = 0;
            m_tmr  = 0;
            m_conf = 1'b0;
            m_busy = 1'b0;
        end else begin
            n        = m_req[0] + m_req[1] + m_req[2];
            ovl      = (n >= 2);
            tick     = (m_tmr == STEP_CYCLES - 1);
            any_move = 1'b0;
            for (int i = 0; i < 3; i++) begin
                mp[i] = (m_lvl[i] > m_cnt);
                tgt   = (m_req[i] == 1 && !ovl) ? int'(brightness) : 0;
`ifdef RGB_FADE_EN
                if (tick && m_lvl[i] < tgt) m_lvl[i] = m_lvl[i] + 1;
                else if (tick && m_lvl[i] > tgt) m_lvl[i] = m_lvl[i] - 1;
                if (m_lvl[i] != tgt) any_move = 1'b1;
`else
                m_lvl[i] = tgt;
`endif
            end
            m_busy = any_move;
            m_cnt  = (m_cnt + 1) % PERIOD;
            m_tmr  = (m_tmr + 1) % STEP_CYCLES;
            m_conf = ovl;
            for (int i = 0; i < 3; i++) m_req[i] = in_req[i];
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) clk_step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        red_in = 1'b1; green_in = 1'b0; blue_in = 1'b0; brightness = 4'd15;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            clk_step();
            checks++;
            if ({red_pwm, green_pwm, blue_pwm, busy, conflict} !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs: got %b expected 00000 (cycle %0d)",
                         {red_pwm, green_pwm, blue_pwm, busy, conflict}, c);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            clk_step();
            checks++;
            if (red_pwm !== mp[0] || busy !== m_busy) begin
                errors++;
                $display("FAIL reset_release: got pwm=%b busy=%b expected pwm=%b busy=%b (cycle %0d)",
                         red_pwm, busy, mp[0], m_busy, c);
            end
        end
    endtask

`ifdef RGB_FADE_EN
    task automatic test_fade_in();
        int busy_cycles = 0;
        red_in = 1'b1; green_in = 1'b0; blue_in = 1'b0; brightness = 4'd15;
        do_reset();
        for (int c = 0; c < 70; c++) begin
            clk_step();
            if (busy === 1'b1) busy_cycles++;
            checks++;
            if (red_pwm !== mp[0] || busy !== m_busy) begin
                errors++;
                $display("FAIL fade_in_track: got pwm=%b busy=%b expected pwm=%b busy=%b (cycle %0d)",
                         red_pwm, busy, mp[0], m_busy, c);
            end
        end
        checks++;
        if (busy_cycles < 55 || busy_cycles > 61) begin
            errors++;
            $display("FAIL fade_in_busy_len: got %0d cycles expected 55..61", busy_cycles);
        end
        for (int c = 0; c < 30; c++) begin
            clk_step();
            checks++;
            if (red_pwm !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL fade_in_full: got pwm=%b busy=%b expected pwm=1 busy=0", red_pwm, busy);
            end
        end
    endtask

    task automatic test_reversal();
        int  guard = 0;
        bit  found = 1'b0;
        red_in = 1'b1; green_in = 1'b0; blue_in = 1'b0; brightness = 4'd15;
        do_reset();
        while (!found && guard < 100) begin
            clk_step();
            guard++;
            if (m_lvl[0] == 6) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reversal_reach6: got no level 6 expected level 6 within 100 cycles");
        end
        red_in = 1'b0;
        for (int c = 0; c < 60; c++) begin
            clk_step();
            checks++;
            if (red_pwm !== mp[0] || busy !== m_busy) begin
                errors++;
                $display("FAIL reversal_track: got pwm=%b busy=%b expected pwm=%b busy=%b (cycle %0d)",
                         red_pwm, busy, mp[0], m_busy, c);
            end
        end
        for (int c = 0; c < 30; c++) begin
            clk_step();
            checks++;
            if (red_pwm !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reversal_off: got pwm=%b busy=%b expected pwm=0 busy=0", red_pwm, busy);
            end
        end
    endtask
`else
    task automatic test_no_fade();
        red_in = 1'b0; green_in = 1'b0; blue_in = 1'b0; brightness = 4'd15;
        do_reset();
        repeat (2) clk_step();
        blue_in = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            clk_step();
            checks++;
            if (blue_pwm !== ((c >= 3) ? 1'b1 : 1'b0) || busy !== 1'b0) begin
                errors++;
                $display("FAIL no_fade_edge: got pwm=%b busy=%b expected pwm=%b busy=0 (clock %0d after edge)",
                         blue_pwm, busy, (c >= 3), c);
            end
        end
    endtask
`endif

    task automatic test_duty();
        int highs;
        red_in = 1'b1; green_in = 1'b0; blue_in = 1'b0; brightness = 4'd15;
        do_reset();
        repeat (70) clk_step();
        brightness = 4'd8;
        for (int c = 0; c < 50; c++) begin
            clk_step();
            checks++;
            if (red_pwm !== mp[0]) begin
                errors++;
                $display("FAIL duty_settle: got %b expected %b (cycle %0d)", red_pwm, mp[0], c);
            end
        end
        for (int w = 0; w < 10; w++) begin
            highs = 0;
            for (int c = 0; c < PERIOD; c++) begin
                clk_step();
                if (red_pwm === 1'b1) highs++;
            end
            checks++;
            if (highs != 8 || busy !== 1'b0) begin
                errors++;
                $display("FAIL duty_window: got %0d highs busy=%b expected 8 highs busy=0 (window %0d)",
                         highs, busy, w);
            end
        end
    endtask

    task automatic test_conflict();
        red_in = 1'b1; green_in = 1'b0; blue_in = 1'b0; brightness = 4'd15;
        do_reset();
        repeat (70) clk_step();
        green_in = 1'b1;
        clk_step();
        checks++;
        if (conflict !== 1'b0) begin
            errors++;
            $display("FAIL conflict_rise_1clk: got %b expected 0", conflict);
        end
        clk_step();
        checks++;
        if (conflict !== 1'b1) begin
            errors++;
            $display("FAIL conflict_rise_2clk: got %b expected 1", conflict);
        end
        for (int c = 0; c < 80; c++) begin
            clk_step();
            checks++;
            if (red_pwm !== mp[0] || green_pwm !== mp[1] || conflict !== m_conf) begin
                errors++;
                $display("FAIL conflict_track: got r=%b g=%b c=%b expected r=%b g=%b c=%b (cycle %0d)",
                         red_pwm, green_pwm, conflict, mp[0], mp[1], m_conf, c);
            end
        end
        for (int c = 0; c < 15; c++) begin
            clk_step();
            checks++;
            if (red_pwm !== 1'b0 || green_pwm !== 1'b0) begin
                errors++;
                $display("FAIL conflict_dark: got r=%b g=%b expected r=0 g=0", red_pwm, green_pwm);
            end
        end
        green_in = 1'b0;
        clk_step();
        checks++;
        if (conflict !== 1'b1) begin
            errors++;
            $display("FAIL conflict_fall_1clk: got %b expected 1", conflict);
        end
        clk_step();
        checks++;
        if (conflict !== 1'b0) begin
            errors++;
            $display("FAIL conflict_fall_2clk: got %b expected 0", conflict);
        end
        for (int c = 0; c < 80; c++) begin
            clk_step();
            checks++;
            if (red_pwm !== mp[0]) begin
                errors++;
                $display("FAIL conflict_recover: got %b expected %b (cycle %0d)", red_pwm, mp[0], c);
            end
        end
        for (int c = 0; c < 15; c++) begin
            clk_step();
            checks++;
            if (red_pwm !== 1'b1 || green_pwm !== 1'b0) begin
                errors++;
                $display("FAIL conflict_red_full: got r=%b g=%b expected r=1 g=0", red_pwm, green_pwm);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] pat;
        red_in = 1'b0; green_in = 1'b0; blue_in = 1'b0; brightness = 4'd0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                pat        = 3'($urandom_range(0, 7));
                red_in     = pat[0];
                green_in   = pat[1];
                blue_in    = pat[2];
                brightness = 4'($urandom_range(0, 15));
            end
            rst = ($urandom_range(0, 199) == 0);
            clk_step();
            checks++;
            if (red_pwm !== mp[0] || green_pwm !== mp[1] || blue_pwm !== mp[2] ||
                busy !== m_busy || conflict !== m_conf) begin
                errors++;
                $display("FAIL random: got rgb=%b%b%b busy=%b conf=%b expected rgb=%b%b%b busy=%b conf=%b (cycle %0d)",
                         red_pwm, green_pwm, blue_pwm, busy, conflict,
                         mp[0], mp[1], mp[2], m_busy, m_conf, c);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef RGB_FADE_EN
        test_fade_in();
        test_reversal();
`else
        test_no_fade();
`endif
        test_duty();
        test_conflict();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_led_pwm_fader.md
Name: rgb_led_pwm_fader

Overview:
- Downstream stage of the traffic-light LED sequencer (red 10 s, green 5 s, blue 2 s at 100 MHz).
- Consumes the sequencer's three on/off LED levels and drives the physical RGB pins.
- Each pin gets PWM brightness control and a linear fade between phases instead of hard switching.
- Detects illegal overlaps, where more than one input is high, and forces the outputs dark while an overlap persists.

Parameters:
- PWM_BITS, 8: width of the brightness levels. The PWM period is 2^PWM_BITS-1 clocks.
- STEP_CYCLES, 390_625: clocks per one-LSB fade step. 255 steps at 100 MHz take about 1 s.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- red_in  in  1  red request from the sequencer.
- green_in  in  1  green request from the sequencer.
- blue_in  in  1  blue request from the sequencer.
- brightness  in  PWM_BITS  global on-level applied to whichever channel is requested.
- red_pwm  out  1  PWM drive to the red LED.
- green_pwm  out  1  PWM drive to the green LED.
- blue_pwm  out  1  PWM drive to the blue LED.
- busy  out  1  high while any channel is ramping.
- conflict  out  1  high while more than one request is active.

Behaviour:
- Clocking and reset:
  - One clock domain, clk; rst is synchronous and active-high.
  - On reset: all levels 0, PWM counter 0, step timer 0, all channels in state OFF.
  - Reset values of outputs: red_pwm, green_pwm, blue_pwm, busy and conflict are all 0.
  - Reset asserted mid-ramp aborts the ramp immediately. No state survives reset.
- Input stage:
  - red_in, green_in and blue_in are registered once (req_r).
  - brightness is sampled combinationally when targets are computed.
- Conflict:
  - ovl is high when two or more bits of req_r are set.
  - conflict is a registered copy of ovl, so it rises 2 clocks after the offending input edge.
  - It is not sticky: it drops 2 clocks after the overlap clears.
- Targets:
  - target_x = (req_r_x && !ovl) ? brightness : 0.
- Step timer:
  - Free-running counter 0..STEP_CYCLES-1.
  - tick is high for one clock when the counter equals STEP_CYCLES-1; the counter then wraps to 0.
- Per-channel FSM (states OFF, UP, ON, DOWN):
  - On every clock, the state is re-evaluated from lvl versus target:
    - lvl < target → UP.
    - lvl > target → DOWN.
    - lvl == target and target == 0 → OFF.
    - lvl == target and target != 0 → ON.
  - lvl changes only on tick: +1 in UP, -1 in DOWN, hold otherwise. It never overshoots the target.
  - A target change mid-ramp takes effect on the next tick and reverses direction from the current lvl, with no jump.
  - If tick and a target change coincide, the step uses the new target.
  - busy = any channel in UP or DOWN, registered.
- PWM:
  - pwm_cnt runs 0..2^PWM_BITS-2, then wraps to 0.
  - x_pwm is the registered value of (lvl_x > pwm_cnt).
  - lvl 0 → output constantly 0; lvl 2^PWM_BITS-1 → output constantly 1.
  - Duty cycle is lvl / (2^PWM_BITS-1).
- Arithmetic: all comparisons are unsigned, PWM_BITS wide. lvl saturates at both 0 and 2^PWM_BITS-1.

Optional Feature:
- Macro: RGB_FADE_EN.
- Defined: fading works as described above.
- Undefined:
  - lvl_x loads target_x on every clock, ignoring tick.
  - The step timer is not instantiated.
  - UP and DOWN are never entered, so busy is tied to 0.
  - A request edge reaches full duty on the PWM outputs 3 clocks after the input edge.
  - Conflict and PWM behaviour are unchanged.

Test Plan (PWM_BITS=4, STEP_CYCLES=4, RGB_FADE_EN defined unless stated):
- Reset: hold rst for 3 clocks with red_in=1 and brightness=15 → all outputs 0 during reset; after release, lvl_red climbs from 0.
- Fade-in: red_in=1, brightness=15 → lvl_red increments once per 4 clocks; busy stays high for 15 ticks (about 60 clocks), then drops; red_pwm is then constantly 1.
- Duty: red_in=1 held, brightness=8, after settling → red_pwm is high exactly 8 of every 15 clocks, stable over 10 periods.
- Reversal: red_in drops when lvl_red=6 → lvl_red steps 5,4,…,0 on successive ticks with no overshoot; state ends in OFF; red_pwm is constantly 0.
- Conflict: red_in and green_in both 1 → conflict=1 two clocks later; both channels fade to 0. Then green_in=0 → conflict=0 two clocks later and red ramps back up.
- No fade (RGB_FADE_EN undefined): blue_in 0→1 with brightness=15 → blue_pwm constantly 1 from the 3rd clock after the edge; busy is 0 throughout.
